// File: rtl/red_pitaya_daisy_link_pkg.sv
// Shared definitions for the daisy-chain link: register map, TX word sources,
// training pattern and the PRBS polynomial used by both TX and the RX checker.
package red_pitaya_daisy_link_pkg;

  localparam logic [4:0] REG_CTRL     = 5'h00;
  localparam logic [4:0] REG_TX_MODE  = 5'h04;
  localparam logic [4:0] REG_RX_TRAIN = 5'h08;
  localparam logic [4:0] REG_STATUS   = 5'h0C;
  localparam logic [4:0] REG_ERR_CTRL = 5'h10;
  localparam logic [4:0] REG_ERR_CNT  = 5'h14;

  typedef enum logic [3:0] {
    MODE_ZERO   = 4'd0,
    MODE_USER   = 4'd1,
    MODE_CUSTOM = 4'd2,
    MODE_TRAIN  = 4'd3,
    MODE_ECHO   = 4'd4,
    MODE_LFSR   = 4'd5
  } tx_mode_e;

  localparam logic [15:0] TRAIN_PAT = 16'h00FF;
  localparam logic [15:0] LFSR_SEED = 16'h0001;

  // Fibonacci x^16 + x^14 + x^13 + x^11 + 1, shifting towards the MSB.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/red_pitaya_daisy_link_if.sv
// System-bus port bundle of the daisy link; the bus host is the master.
interface red_pitaya_daisy_link_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic        wen;
  logic        ren;
  logic [31:0] rdata;
  logic        err;
  logic        ack;

  modport master (output addr, wdata, sel, wen, ren, input rdata, err, ack);
  modport slave  (input addr, wdata, sel, wen, ren, output rdata, err, ack);
endinterface

// File: rtl/red_pitaya_daisy_lfsr.sv
// PRBS generator for TX data; also exposes the polynomial step combinationally
// so the RX checker can predict the successor of the last received word.
module red_pitaya_daisy_lfsr
  import red_pitaya_daisy_link_pkg::*;
(
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        adv_i,
  output logic [15:0] state_o,
  input  logic [15:0] chk_i,
  output logic [15:0] chk_next_o
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      lfsr_q <= LFSR_SEED;
    end else if (adv_i) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign state_o    = lfsr_q;
  assign chk_next_o = lfsr_next(chk_i);

endmodule

// File: rtl/red_pitaya_daisy_link.sv
// Daisy-chain link: 16-bit serializer/deserializer with word-alignment training,
// PRBS error counter and a small register bank on the system bus.
module red_pitaya_daisy_link
  import red_pitaya_daisy_link_pkg::*;
(
  input  logic                          sys_clk_i,
  input  logic                          sys_rstn_i,
  red_pitaya_daisy_link_if.slave        sys_bus,
  output logic [1:0]                    daisy_p_o,
  output logic [1:0]                    daisy_n_o,
  input  logic [1:0]                    daisy_p_i,
  input  logic [1:0]                    daisy_n_i,
  output logic                          par_rdy_o,
  input  logic                          par_dv_i,
  input  logic [15:0]                   par_dat_i,
  output logic                          par_dv_o,
  output logic [15:0]                   par_dat_o
);

  logic        tx_en_q, rx_en_q, train_en_q, train_prev_q, err_clr_q;
  logic [3:0]  tx_mode_q;
  logic [15:0] custom_q;
  logic [31:0] err_cnt_q, rdata_d, rdata_q;
  logic        ack_q;

  logic [3:0]  bc_q;
  logic [15:0] tx_sr_q, tx_word_d, lfsr_q;
  logic        tx_bit_q, tx_load, lfsr_adv;

  logic [1:0]  rx_in_q;
  logic [3:0]  rc_q, slip_cnt_q;
  logic [15:0] rx_sr_q, rx_bits, rx_word_q, prev_word_q, chk_next;
  logic        hold_q, locked_q, dv_q, prev_valid_q;
  logic        rx_act, capture, slip, deliver;

  logic unused_ok;
  assign unused_ok = &{1'b0, daisy_n_i, sys_bus.sel, sys_bus.addr[31:5], sys_bus.wdata[15:4]};

  // Register bank: one-cycle registered ack/rdata, writes land on the same edge.
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      tx_en_q    <= 1'b0;
      rx_en_q    <= 1'b0;
      tx_mode_q  <= '0;
      custom_q   <= '0;
      train_en_q <= 1'b0;
      err_clr_q  <= 1'b0;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (sys_bus.wen) begin
        case (sys_bus.addr[4:0])
          REG_CTRL:     {rx_en_q, tx_en_q} <= sys_bus.wdata[1:0];
          REG_TX_MODE:  begin
            tx_mode_q <= sys_bus.wdata[3:0];
            custom_q  <= sys_bus.wdata[31:16];
          end
          REG_RX_TRAIN: train_en_q <= sys_bus.wdata[0];
          REG_ERR_CTRL: err_clr_q  <= sys_bus.wdata[0];
          default: ;
        endcase
      end
      ack_q   <= sys_bus.wen | sys_bus.ren;
      rdata_q <= sys_bus.ren ? rdata_d : '0;
    end
  end

  always_comb begin
    // NOTE: default assigned first so no path through the case infers a latch.
    rdata_d = '0;
    case (sys_bus.addr[4:0])
      REG_CTRL:     rdata_d = {30'd0, rx_en_q, tx_en_q};
      REG_TX_MODE:  rdata_d = {custom_q, 12'd0, tx_mode_q};
      REG_RX_TRAIN: rdata_d = {31'd0, train_en_q};
      REG_STATUS:   rdata_d = {rx_word_q, 8'd0, slip_cnt_q, 3'd0, locked_q};
      REG_ERR_CTRL: rdata_d = {31'd0, err_clr_q};
      REG_ERR_CNT:  rdata_d = err_cnt_q;
      default: ;
    endcase
  end

  assign sys_bus.rdata = rdata_q;
  assign sys_bus.ack   = ack_q;
  assign sys_bus.err   = 1'b0;

  // TX word source, sampled only on the load cycle (bc == 15).
  always_comb begin
    tx_word_d = '0;
    case (tx_mode_q)
      MODE_USER:   tx_word_d = par_dv_i ? par_dat_i : '0;
      MODE_CUSTOM: tx_word_d = custom_q;
      MODE_TRAIN:  tx_word_d = TRAIN_PAT;
      MODE_ECHO:   tx_word_d = rx_word_q;
      MODE_LFSR:   tx_word_d = lfsr_q;
      default: ;
    endcase
  end

  assign tx_load  = tx_en_q && (bc_q == 4'd15);
  assign lfsr_adv = tx_load && (tx_mode_q == MODE_LFSR);

  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      bc_q     <= '0;
      tx_sr_q  <= '0;
      tx_bit_q <= 1'b0;
    end else if (!tx_en_q) begin
      bc_q     <= '0;
      tx_sr_q  <= '0;
      tx_bit_q <= 1'b0;
    end else begin
      bc_q     <= bc_q + 4'd1;
      tx_bit_q <= tx_sr_q[15];
      tx_sr_q  <= tx_load ? tx_word_d : {tx_sr_q[14:0], 1'b0};
    end
  end

  // Gating with tx_en_q drops both lanes on the very edge that disables TX.
  assign daisy_p_o = {tx_en_q, tx_en_q & tx_bit_q};
  assign daisy_n_o = ~daisy_p_o;
  assign par_rdy_o = tx_en_q && (tx_mode_q == MODE_USER) && (bc_q == 4'd14);

  red_pitaya_daisy_lfsr u_lfsr (
    .clk_i      (sys_clk_i),
    .rstn_i     (sys_rstn_i),
    .adv_i      (lfsr_adv),
    .state_o    (lfsr_q),
    .chk_i      (prev_word_q),
    .chk_next_o (chk_next)
  );

  assign rx_act  = rx_en_q & rx_in_q[1];
  assign rx_bits = {rx_sr_q[14:0], rx_in_q[0]};
  assign capture = rx_act && (rc_q == 4'd15);
  assign slip    = capture && train_en_q && !locked_q && (rx_bits != TRAIN_PAT);
  assign deliver = capture && locked_q && !train_en_q;

  // A slip parks the counter at 0 for one extra cycle, moving the word boundary by one bit.
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      rx_in_q      <= '0;
      rx_sr_q      <= '0;
      rc_q         <= '0;
      hold_q       <= 1'b0;
      rx_word_q    <= '0;
      slip_cnt_q   <= '0;
      locked_q     <= 1'b0;
      train_prev_q <= 1'b0;
      dv_q         <= 1'b0;
    end else begin
      rx_in_q      <= daisy_p_i;
      train_prev_q <= train_en_q;
      dv_q         <= deliver;
      if (!rx_act) begin
        rc_q   <= '0;
        hold_q <= 1'b0;
      end else begin
        rx_sr_q <= rx_bits;
        rc_q    <= hold_q ? rc_q : rc_q + 4'd1;
        hold_q  <= slip;
      end
      if (capture) rx_word_q <= rx_bits;
      if (slip) slip_cnt_q <= slip_cnt_q + 4'd1;
      if (!rx_en_q || (train_en_q && !train_prev_q)) begin
        locked_q <= 1'b0;
      end else if (capture && train_en_q && !locked_q && rx_bits == TRAIN_PAT) begin
        locked_q <= 1'b1;
      end
    end
  end

  assign par_dv_o  = dv_q;
  assign par_dat_o = rx_word_q;

  // PRBS checker: each delivered word must be the polynomial successor of the previous one.
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      prev_word_q  <= '0;
      prev_valid_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      if (!locked_q) begin
        prev_valid_q <= 1'b0;
      end else if (deliver) begin
        prev_word_q  <= rx_bits;
        prev_valid_q <= 1'b1;
      end
      if (err_clr_q) begin
        err_cnt_q <= '0;
      end else if (deliver && tx_mode_q == MODE_LFSR && prev_valid_q &&
                   rx_bits != chk_next && err_cnt_q != 32'hFFFF_FFFF) begin
        err_cnt_q <= err_cnt_q + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_red_pitaya_daisy_link.sv
// Loopback bench for red_pitaya_daisy_link: register map, training, user/custom/PRBS
// traffic and error counting, checked against an independent word-level model.
module tb_red_pitaya_daisy_link;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  red_pitaya_daisy_link_if sys_bus ();

  logic [1:0]  p_o, n_o, p_i, n_i;
  logic        flip = 1'b0;
  logic        rdy, dv_o;
  logic        dv_i = 1'b0;
  logic [15:0] dat_i = '0;
  logic [15:0] dat_o;

  assign p_i = p_o ^ {1'b0, flip};
  assign n_i = ~p_i;

  red_pitaya_daisy_link dut (
    .sys_clk_i  (clk),
    .sys_rstn_i (rst_n),
    .sys_bus    (sys_bus),
    .daisy_p_o  (p_o),
    .daisy_n_o  (n_o),
    .daisy_p_i  (p_i),
    .daisy_n_i  (n_i),
    .par_rdy_o  (rdy),
    .par_dv_i   (dv_i),
    .par_dat_i  (dat_i),
    .par_dv_o   (dv_o),
    .par_dat_o  (dat_o)
  );

  localparam logic [31:0] A_CTRL = 32'h00, A_MODE = 32'h04, A_TRAIN = 32'h08;
  localparam logic [31:0] A_STAT = 32'h0C, A_ECTL = 32'h10, A_ECNT = 32'h14;

  int vectors = 0;
  int miscompares = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    sys_bus.addr = a; sys_bus.wdata = d; sys_bus.sel = 4'hF; sys_bus.wen = 1'b1;
    @(negedge clk);
    sys_bus.wen = 1'b0;
    check("wr_ack", 32'(sys_bus.ack), 32'd1);
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    sys_bus.addr = a; sys_bus.ren = 1'b1;
    @(negedge clk);
    sys_bus.ren = 1'b0;
    d = sys_bus.rdata;
    check("rd_ack", 32'(sys_bus.ack), 32'd1);
  endtask

  // Reference PRBS step: feedback is the parity of taps 16,14,13,11.
  function automatic logic [15:0] ref_lfsr(input logic [15:0] w);
    return {w[14:0], ^(w & 16'hB400)};
  endfunction

  logic [15:0] rx_q[$];
  int unsigned rx_t[$];
  always @(negedge clk) if (dv_o) begin
    rx_q.push_back(dat_o);
    rx_t.push_back(cyc);
  end

  // User-word source: answers par_rdy_o one cycle later, randomly skipping words.
  bit          drv_en = 1'b0;
  logic [15:0] drv_cnt = 16'd1;
  logic [15:0] exp_q[$];
  initial forever begin
    @(negedge clk);
    if (drv_en && rdy) begin
      @(posedge clk); #1;
      if (drv_cnt == 16'd1 || $urandom_range(0, 3) != 0) begin
        dv_i = 1'b1; dat_i = drv_cnt;
        exp_q.push_back(drv_cnt);
        drv_cnt++;
      end else begin
        dat_i = 16'($urandom);
        exp_q.push_back(16'h0000);
      end
      @(posedge clk); #1;
      dv_i = 1'b0; dat_i = 16'($urandom);
    end
  end

  task automatic wait_words(input int n, input int budget, input string tag);
    int t = 0;
    while (rx_q.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(rx_q.size() >= n), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, st;
    logic [15:0] m;
    int unsigned t0;
    bit locked;
    sys_bus.addr = '0; sys_bus.wdata = '0; sys_bus.sel = '0;
    sys_bus.wen = 1'b0; sys_bus.ren = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_p", 32'(p_o), 32'd0);
    check("rst_n_lanes", 32'(n_o), 32'd3);
    check("rst_rdy", 32'(rdy), 32'd0);
    check("rst_err", 32'(sys_bus.err), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus_rd(32'(i * 4), d);
      check("rst_reg", d, 32'd0);
    end

    // Random register traffic while the link is idle.
    for (int i = 0; i < 6; i++) begin
      logic [31:0] r = $urandom;
      bus_wr(A_MODE, r);
      bus_rd(A_MODE, d);
      check("mode_rb", d, r & 32'hFFFF_000F);
      r = $urandom;
      bus_wr(A_TRAIN, r);
      bus_rd(A_TRAIN, d);
      check("train_rb", d, r & 32'h1);
    end
    bus_wr(A_STAT, 32'hFFFF_FFFF);
    bus_rd(A_STAT, d);
    check("status_ro", d, 32'd0);
    bus_wr(A_ECTL, 32'h1);
    bus_rd(A_ECTL, d);
    check("ectl_rb", d, 32'd1);
    bus_wr(A_ECTL, 32'h0);

    // Training on loopback.
    bus_wr(A_TRAIN, 32'h1);
    bus_wr(A_MODE, 32'h3);
    t0 = cyc;
    bus_wr(A_CTRL, 32'h3);
    locked = 1'b0;
    st = '0;
    while (!locked && (cyc - t0) < 300) begin
      bus_rd(A_STAT, st);
      locked = st[0];
    end
    check("lock", 32'(locked), 32'd1);
    check("lock_word", 32'(st[31:16]), 32'h00FF);

    // Custom value stream: one word every 16 clocks.
    bus_wr(A_TRAIN, 32'h0);
    bus_wr(A_MODE, 32'hF419_0002);
    repeat (64) @(negedge clk);
    rx_q.delete(); rx_t.delete();
    wait_words(8, 200, "custom_timeout");
    for (int i = 0; i < 8 && i < rx_q.size(); i++) check("custom_dat", 32'(rx_q[i]), 32'hF419);
    for (int i = 1; i < 8 && i < rx_q.size(); i++) check("custom_gap", rx_t[i] - rx_t[i-1], 32'd16);

    // User words in order; skipped slots carry 0x0000.
    exp_q.delete();
    drv_en = 1'b1;
    bus_wr(A_MODE, 32'h1);
    rx_q.delete();
    wait_words(24, 24 * 16 + 200, "user_timeout");
    drv_en = 1'b0;
    while (rx_q.size() > 0 && (rx_q[0] == 16'hF419 || rx_q[0] == 16'h0000)) void'(rx_q.pop_front());
    check("user_count", 32'(rx_q.size() >= 12 && exp_q.size() >= 12), 32'd1);
    for (int i = 0; i < 12 && i < rx_q.size() && i < exp_q.size(); i++)
      check("user_dat", 32'(rx_q[i]), 32'(exp_q[i]));

    // PRBS stream starts from the reset seed.
    bus_wr(A_MODE, 32'h0);
    repeat (64) @(negedge clk);
    rx_q.delete();
    bus_wr(A_MODE, 32'h5);
    wait_words(24, 24 * 16 + 200, "lfsr_timeout");
    while (rx_q.size() > 0 && rx_q[0] == 16'h0000) void'(rx_q.pop_front());
    m = 16'h0001;
    for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
      check("lfsr_dat", 32'(rx_q[i]), 32'(m));
      m = ref_lfsr(m);
    end

    // Error counter: held at 0 while cleared, silent on clean data, counts a flipped bit.
    bus_wr(A_ECTL, 32'h1);
    bus_rd(A_ECNT, d);
    check("ecnt_clr", d, 32'd0);
    bus_wr(A_ECTL, 32'h0);
    repeat (400 * 16) @(negedge clk);
    bus_rd(A_ECNT, d);
    check("ecnt_clean", d, 32'd0);
    @(negedge clk); flip = 1'b1;
    @(negedge clk); flip = 1'b0;
    repeat (64) @(negedge clk);
    bus_rd(A_ECNT, d);
    check("ecnt_flip", 32'(d >= 1 && d <= 2), 32'd1);
    bus_wr(A_ECTL, 32'h1);
    bus_rd(A_ECNT, d);
    check("ecnt_clr2", d, 32'd0);
    bus_wr(A_ECTL, 32'h0);

    // Unmapped space.
    bus_wr(32'h18, $urandom);
    bus_rd(32'h18, d);
    check("unmapped_18", d, 32'd0);
    bus_rd(32'h1C, d);
    check("unmapped_1c", d, 32'd0);

    // Disable mid-word.
    repeat ($urandom_range(1, 15)) @(negedge clk);
    bus_wr(A_CTRL, 32'h0);
    check("off_p", 32'(p_o), 32'd0);
    @(negedge clk);
    check("off_p_next", 32'(p_o), 32'd0);
    check("off_n_next", 32'(n_o), 32'd3);
    check("off_rdy", 32'(rdy), 32'd0);
    bus_rd(A_STAT, d);
    check("off_unlock", 32'(d[0]), 32'd0);

    // Asynchronous reset mid-word.
    bus_wr(A_CTRL, 32'h3);
    bus_wr(A_MODE, 32'h5);
    repeat (37) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("areset_p", 32'(p_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_rd(A_CTRL, d);
    check("areset_ctrl", d, 32'd0);
    bus_rd(A_MODE, d);
    check("areset_mode", d, 32'd0);
    bus_rd(A_STAT, d);
    check("areset_stat", d, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
